fft_cbfp_lzc_tracker: RTL and testbench
=======================================

FFT_CBFP_LZC_TRACKER -- requirements
Module: fft_cbfp_lzc_tracker

Interface
- REQ-001: Parameter LANES, default 16: complex samples per input beat.
- REQ-002: Parameter DIN_W, default 23: signed width of each re/im component.
- REQ-003: Parameter BEATS_PER_BLK, default 4: beats per CBFP block; minimum 1.
- REQ-004: Parameter DEPTH, default 4: shift-value FIFO entries; power of 2, minimum 2.
- REQ-005: Derived localparams:
  - SH_W = $clog2(DIN_W).
  - LV_W = $clog2(DEPTH+1).
- REQ-006: clk  in  1  clock; all state updates on its rising edge.
- REQ-007: rstn  in  1  reset; asynchronous, active-low.
- REQ-008: clear  in  1  synchronous flush of the partial block and the FIFO.
- REQ-009: in_valid  in  1  input beat valid.
- REQ-010: in_ready  out  1  input beat accepted when in_valid && in_ready.
- REQ-011: din_re  in  LANES x DIN_W signed  real parts.
- REQ-012: din_im  in  LANES x DIN_W signed  imaginary parts.
- REQ-013: out_valid  out  1  FIFO head holds a block shift value.
- REQ-014: out_ready  in  1  consumer pops the head when out_valid && out_ready.
- REQ-015: out_shift  out  SH_W  block shift value: minimum redundant-sign-bit count of the block.
- REQ-016: level  out  LV_W  current FIFO occupancy.
- REQ-017: ovf_err  out  1  sticky flag: a block-complete push was attempted while the FIFO was full.

Function
- REQ-018: Per component x, rsb(x) = (number of consecutive MSB-side bits equal to the sign bit) - 1; range 0..DIN_W-1.
  - 0 and -1 give DIN_W-1.
  - Most-positive and most-negative values give 0.
- REQ-019: beat_min = combinational minimum of rsb over all 2*LANES components of the current beat.
- REQ-020: beat_cnt counts accepted beats and runs 0..BEATS_PER_BLK-1.
  - It increments on each accepted beat.
  - It wraps to 0 after the last beat of a block.
- REQ-021: acc_min holds the running minimum of the block.
  - On an accepted beat with beat_cnt==0, acc_min loads beat_min.
  - On any other accepted beat, acc_min loads min(acc_min, beat_min).
- REQ-022: On an accepted beat with beat_cnt==BEATS_PER_BLK-1:
  - min(acc_min, beat_min) is written to the FIFO tail in that same cycle.
  - When BEATS_PER_BLK==1, the value written is beat_min.
- REQ-023: A pushed value appears at out_shift with out_valid=1 no earlier than the next cycle; latency from the last accepted beat is exactly 1 cycle when the FIFO was empty.
- REQ-024: in_ready = !(level==DEPTH && beat_cnt==BEATS_PER_BLK-1).
  - Non-final beats are accepted while the FIFO is full.
  - A pop in the same cycle does not raise in_ready; the path is registered only.
- REQ-025: out_valid = (level != 0).
  - out_shift is driven from the FIFO head.
  - out_shift is stable while out_valid && !out_ready.
- REQ-026: Simultaneous push and pop leaves level unchanged and preserves FIFO order; the read and write pointers wrap modulo DEPTH.
- REQ-027: ovf_err sets if an internal push occurs while level==DEPTH.
  - This cannot happen in normal operation, because in_ready blocks it.
  - The flag covers protocol violations only.
  - It clears only on reset or clear.
- REQ-028: When clear=1:
  - beat_cnt, acc_min, level, the pointers and ovf_err return to their reset values on the next edge.
  - in_valid and out_ready are ignored in that cycle.
  - clear has priority over all other updates.
- REQ-029: in_valid is ignored while in_ready=0; input data need not be held.

Reset
- REQ-030: While rstn=0:
  - in_ready=1, out_valid=0, out_shift=0, level=0, ovf_err=0.
  - beat_cnt=0, acc_min=DIN_W-1, pointers=0.
- REQ-031: Reset asserted mid-block discards the partial block and all FIFO content; the first beat after release starts a new block.
- REQ-032: FIFO storage need not be reset, but out_shift shall read 0 whenever out_valid=0.

Verification (defaults LANES=16, DIN_W=23, BEATS_PER_BLK=4, DEPTH=4)
- REQ-033: One block, 4 beats of all-zero data except one beat containing re=0x000100 -> out_valid 1 cycle after beat 4, out_shift=13.
- REQ-034: Beats containing im=-4194304 (most negative) and re=-1 -> out_shift=0.
- REQ-035: Fill 4 blocks with out_ready=0, then offer a 5th block:
  - The first 3 beats are accepted.
  - On the 4th beat, in_ready=0, level=4, ovf_err=0.
  - Popping one entry raises in_ready on the next cycle.
- REQ-036: Simultaneous final-beat push and pop at level=2 -> level stays 2 and the popped values come out in push order.
- REQ-037: Assert clear after 2 beats with 1 entry queued -> level=0, out_valid=0; the next 4 beats form a fresh block whose out_shift excludes the pre-clear beats.
- REQ-038: Pulse rstn low mid-block -> all outputs take REQ-030 values asynchronously; the block after release matches the reference model.

Source files
------------

// File: rtl/fft_cbfp_lzc_tracker.sv
// Block-floating-point exponent tracker: finds the minimum redundant-sign-bit
// count over each block of FFT beats and queues one shift value per block.

module cbfp_lane #(
   parameter int DIN_W = 23,
   parameter int SH_W  = 5
) (
   input  logic [DIN_W-1:0] re,
   input  logic [DIN_W-1:0] im,
   output logic [SH_W-1:0]  lane_min
);

   // Fold the sign into the magnitude bits; redundant sign bits become leading zeros.
   function automatic logic [SH_W-1:0] rsb(input logic [DIN_W-1:0] x);
      logic [DIN_W-2:0] y;
      logic [SH_W-1:0]  n;
      y = x[DIN_W-2:0] ^ {(DIN_W-1){x[DIN_W-1]}};
      n = SH_W'(DIN_W-1);
      for (int i = 0; i < DIN_W-1; i++)
         if (y[i]) n = SH_W'(DIN_W-2-i);
      return n;
   endfunction

   logic [SH_W-1:0] rsb_re, rsb_im;

   always_comb begin
      rsb_re   = rsb(re);
      rsb_im   = rsb(im);
      lane_min = (rsb_re < rsb_im) ? rsb_re : rsb_im;
   end

endmodule

module fft_cbfp_lzc_tracker #(
   parameter  int LANES         = 16,
   parameter  int DIN_W         = 23,
   parameter  int BEATS_PER_BLK = 4,
   parameter  int DEPTH         = 4,
   localparam int SH_W          = $clog2(DIN_W),
   localparam int LV_W          = $clog2(DEPTH+1)
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         clear,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [LANES-1:0][DIN_W-1:0]  din_re,
   input  logic [LANES-1:0][DIN_W-1:0]  din_im,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [SH_W-1:0]              out_shift,
   output logic [LV_W-1:0]              level,
   output logic                         ovf_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = (BEATS_PER_BLK > 1) ? $clog2(BEATS_PER_BLK) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_BLK-1);
   localparam logic [LV_W-1:0]  FULL_LVL  = LV_W'(DEPTH);
   localparam logic [SH_W-1:0]  MAX_RSB   = SH_W'(DIN_W-1);

   logic [LANES-1:0][SH_W-1:0] lane_min;
   logic [SH_W-1:0]            beat_min;
   logic [SH_W-1:0]            blk_min;
   logic [SH_W-1:0]            acc_min;
   logic [CNT_W-1:0]           beat_cnt;
   logic [PTR_W-1:0]           wptr, rptr;
   logic [SH_W-1:0]            mem [DEPTH];
   logic                       accept, last, full, push, do_push, pop;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      cbfp_lane #(.DIN_W(DIN_W), .SH_W(SH_W)) u_lane (
         .re       (din_re[g]),
         .im       (din_im[g]),
         .lane_min (lane_min[g])
      );
   end

   always_comb begin
      beat_min = MAX_RSB;
      for (int l = 0; l < LANES; l++)
         if (lane_min[l] < beat_min) beat_min = lane_min[l];
   end

   // The first beat of a block ignores the stale accumulator, which also
   // makes single-beat blocks push beat_min directly.
   always_comb begin
      if (beat_cnt == '0) blk_min = beat_min;
      else                blk_min = (beat_min < acc_min) ? beat_min : acc_min;
   end

   assign last      = (beat_cnt == LAST_BEAT);
   assign full      = (level == FULL_LVL);
   assign in_ready  = !(full && last);
   assign accept    = in_valid && in_ready;
   assign push      = accept && last;
   assign do_push   = push && !full;
   assign pop       = out_ready && (level != '0);
   assign out_valid = (level != '0);
   assign out_shift = out_valid ? mem[rptr] : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat_cnt <= '0;
         acc_min  <= MAX_RSB;
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         ovf_err  <= 1'b0;
      end else if (clear) begin
         beat_cnt <= '0;
         acc_min  <= MAX_RSB;
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         ovf_err  <= 1'b0;
      end else begin
         if (accept) begin
            beat_cnt <= last ? '0 : beat_cnt + 1'b1;
            acc_min  <= blk_min;
         end
         if (do_push) wptr <= wptr + 1'b1;
         if (pop)     rptr <= rptr + 1'b1;
         case ({do_push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (push && full) ovf_err <= 1'b1;
      end
   end

   // Storage is not reset; out_shift is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (!clear && do_push) mem[wptr] <= blk_min;
   end

endmodule

// File: tb/tb_fft_cbfp_lzc_tracker.sv
// Directed bench for fft_cbfp_lzc_tracker at default parameters.

module tb_fft_cbfp_lzc_tracker;

   localparam int LANES = 16;
   localparam int DIN_W = 23;

   logic                        clk = 1'b0;
   logic                        rstn = 1'b0;
   logic                        clear = 1'b0;
   logic                        in_valid = 1'b0;
   logic                        in_ready;
   logic [LANES-1:0][DIN_W-1:0] din_re = '0;
   logic [LANES-1:0][DIN_W-1:0] din_im = '0;
   logic                        out_valid;
   logic                        out_ready = 1'b0;
   logic [4:0]                  out_shift;
   logic [2:0]                  level;
   logic                        ovf_err;

   int total = 0;
   int bad   = 0;

   fft_cbfp_lzc_tracker dut (
      .clk       (clk),
      .rstn      (rstn),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din_re    (din_re),
      .din_im    (din_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_shift (out_shift),
      .level     (level),
      .ovf_err   (ovf_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One accepted-or-offered beat: all lanes zero except one lane.
   task automatic beat(input int lane, input logic [DIN_W-1:0] re, input logic [DIN_W-1:0] im);
      din_re = '0;
      din_im = '0;
      din_re[lane] = re;
      din_im[lane] = im;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      din_re = '0;
      din_im = '0;
   endtask

   task automatic test_reset();
      #2;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      total++; if (out_shift !== 5'd0) begin bad++; $display("FAIL rst_out_shift got=%0d exp=0", out_shift); end
      total++; if (level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
      total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", ovf_err); end
      #10 rstn = 1'b1;
      step();
   endtask

   task automatic test_basic();
      out_ready = 1'b0;
      beat(0, '0, '0);
      beat(3, 23'h000100, '0);
      beat(0, '0, '0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
      beat(0, '0, '0);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
      total++; if (out_shift !== 5'd13) begin bad++; $display("FAIL basic_shift got=%0d exp=13", out_shift); end
      total++; if (level !== 3'd1) begin bad++; $display("FAIL basic_level got=%0d exp=1", level); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (level !== 3'd0 || out_shift !== 5'd0) begin bad++; $display("FAIL basic_pop got=%0d/%0d exp=0/0", level, out_shift); end
   endtask

   task automatic test_extremes();
      logic [4:0] exp_q [4] = '{5'd0, 5'd22, 5'd0, 5'd10};
      // most negative im plus -1 re
      beat(5, '0, 23'h400000); beat(0, 23'h7FFFFF, '0); beat(0, '0, '0); beat(0, '0, '0);
      // only 0 and -1 everywhere
      beat(2, 23'h7FFFFF, 23'h7FFFFF); beat(0, '0, '0); beat(0, '0, '0); beat(0, '0, '0);
      // most positive on the final beat
      beat(0, '0, '0); beat(0, '0, '0); beat(0, '0, '0); beat(15, 23'h3FFFFF, '0);
      // mixed: 13 then a -4096 giving 10
      beat(1, 23'h000100, '0); beat(0, '0, '0); beat(9, '0, 23'h7FF000); beat(0, '0, '0);
      total++; if (level !== 3'd4) begin bad++; $display("FAIL ext_level got=%0d exp=4", level); end
      for (int i = 0; i < 4; i++) begin
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ext_valid[%0d] got=%b exp=1", i, out_valid); end
         total++; if (out_shift !== exp_q[i]) begin bad++; $display("FAIL ext_shift[%0d] got=%0d exp=%0d", i, out_shift, exp_q[i]); end
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
   endtask

   task automatic test_full();
      logic [4:0] exp_q [4] = '{5'd16, 5'd15, 5'd14, 5'd13};
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++)
         for (int b = 0; b < 4; b++)
            if (b == k) beat(k, 23'(1) << (k+4), '0);
            else        beat(0, '0, '0);
      total++; if (level !== 3'd4) begin bad++; $display("FAIL full_level got=%0d exp=4", level); end
      beat(0, 23'h000100, '0);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_nonfinal_ready got=%b exp=1", in_ready); end
      beat(0, '0, '0);
      beat(0, '0, '0);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", in_ready); end
      total++; if (level !== 3'd4) begin bad++; $display("FAIL full_level4 got=%0d exp=4", level); end
      total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL full_ovf got=%b exp=0", ovf_err); end
      // offered final beat is blocked
      beat(0, '0, '0);
      total++; if (level !== 3'd4 || in_ready !== 1'b0) begin bad++; $display("FAIL full_blocked got=%0d/%b exp=4/0", level, in_ready); end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_same_cycle_ready got=%b exp=0", in_ready); end
      total++; if (out_shift !== 5'd17) begin bad++; $display("FAIL full_head got=%0d exp=17", out_shift); end
      step();
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1 || level !== 3'd3) begin bad++; $display("FAIL full_after_pop got=%b/%0d exp=1/3", in_ready, level); end
      beat(0, '0, '0);
      total++; if (level !== 3'd4 || ovf_err !== 1'b0) begin bad++; $display("FAIL full_refill got=%0d/%b exp=4/0", level, ovf_err); end
      for (int i = 0; i < 4; i++) begin
         total++; if (out_shift !== exp_q[i]) begin bad++; $display("FAIL full_drain[%0d] got=%0d exp=%0d", i, out_shift, exp_q[i]); end
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      beat(0, 23'(1) << 12, '0); beat(0, '0, '0); beat(0, '0, '0); beat(0, '0, '0);
      beat(0, '0, '0); beat(0, '0, '0); beat(4, 23'(1) << 3, '0); beat(0, '0, '0);
      total++; if (level !== 3'd2) begin bad++; $display("FAIL b2b_setup got=%0d exp=2", level); end
      beat(0, 23'(1) << 6, '0); beat(0, '0, '0); beat(0, '0, '0);
      out_ready = 1'b1;
      #1;
      total++; if (out_shift !== 5'd9) begin bad++; $display("FAIL b2b_head got=%0d exp=9", out_shift); end
      beat(0, '0, '0);
      out_ready = 1'b0;
      total++; if (level !== 3'd2) begin bad++; $display("FAIL b2b_level got=%0d exp=2", level); end
      total++; if (out_shift !== 5'd18) begin bad++; $display("FAIL b2b_second got=%0d exp=18", out_shift); end
      out_ready = 1'b1;
      step();
      total++; if (out_shift !== 5'd15) begin bad++; $display("FAIL b2b_third got=%0d exp=15", out_shift); end
      step();
      out_ready = 1'b0;
      total++; if (level !== 3'd0) begin bad++; $display("FAIL b2b_drained got=%0d exp=0", level); end
   endtask

   task automatic test_clear();
      out_ready = 1'b0;
      beat(0, 23'(1) << 1, '0); beat(0, '0, '0); beat(0, '0, '0); beat(0, '0, '0);
      beat(0, '0, 23'h400000);
      beat(0, 23'h400000, '0);
      total++; if (level !== 3'd1) begin bad++; $display("FAIL clr_setup got=%0d exp=1", level); end
      clear = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      step();
      clear = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      total++; if (level !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL clr_state got=%0d/%b exp=0/0", level, out_valid); end
      total++; if (out_shift !== 5'd0) begin bad++; $display("FAIL clr_shift got=%0d exp=0", out_shift); end
      beat(0, '0, '0); beat(7, 23'(1) << 10, '0); beat(0, '0, '0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_early got=%b exp=0", out_valid); end
      beat(0, '0, '0);
      total++; if (level !== 3'd1 || out_shift !== 5'd11) begin bad++; $display("FAIL clr_fresh got=%0d/%0d exp=1/11", level, out_shift); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      beat(0, '0, '0); beat(0, '0, '0); beat(0, '0, '0); beat(0, '0, '0);
      beat(0, 23'h400000, '0);
      beat(0, '0, '0);
      #2 rstn = 1'b0;
      #1;
      total++; if (level !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL arst_state got=%0d/%b exp=0/0", level, out_valid); end
      total++; if (out_shift !== 5'd0 || in_ready !== 1'b1 || ovf_err !== 1'b0) begin bad++; $display("FAIL arst_outs got=%0d/%b/%b exp=0/1/0", out_shift, in_ready, ovf_err); end
      #2 rstn = 1'b1;
      beat(4, 23'(1) << 2, '0); beat(0, '0, '0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_early got=%b exp=0", out_valid); end
      beat(0, '0, '0); beat(0, '0, '0);
      total++; if (level !== 3'd1 || out_shift !== 5'd19) begin bad++; $display("FAIL arst_block got=%0d/%0d exp=1/19", level, out_shift); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_full();
      test_back_to_back();
      test_clear();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
